// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges a cache's whole-line read/write requests to a
// burst memory that moves one s_burst-bit beat per resp_i acknowledge.
// Latency: request sampled at edge 0, beats at edges 1..beats at the earliest,
//   resp_o high after edge beats+1; memory stalls by withholding resp_i.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   line_i / line_o            writeback line in / assembled fill line out
//   address_i, read_i, write_i cache request (levels held until resp_o)
//   resp_o                     one-cycle completion pulse to the cache
//   burst_i / burst_o          memory read beat in / write beat out
//   address_o, read_o, write_o line-aligned memory address and requests
//   resp_i                     memory beat acknowledge
// Optional feature: define CACHELINE_ADAPTOR_PERF_EN to add the rd_count and
//   wr_count completion counters (32-bit, wrapping).
module cacheline_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
`ifdef CACHELINE_ADAPTOR_PERF_EN
  ,
  output logic [31:0]        rd_count,
  output logic [31:0]        wr_count
`endif
);

  localparam int beats = s_line / s_burst;
  localparam int cw    = (beats > 1) ? $clog2(beats) : 1;
  localparam int offw  = $clog2(s_line / 8);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state, state_next;
  logic [cw-1:0]     cnt;
  logic [s_line-1:0] line_q;
  logic [31:0]       addr_q;
  logic              op_wr;
  logic              start_rd, start_wr, beat_ack, last_beat;

  assign last_beat = (cnt == cw'(beats - 1));

  // In the cycle resp_o is high the cache still holds its old request level,
  // so IDLE ignores requests until the pulse has gone; otherwise the finished
  // transfer would be restarted.
  always_comb begin
    state_next = state;
    start_rd   = 1'b0;
    start_wr   = 1'b0;
    beat_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (!resp_o) begin
          if (write_i) begin
            start_wr   = 1'b1;
            state_next = WRITE;
          end else if (read_i) begin
            start_rd   = 1'b1;
            state_next = READ;
          end
        end
      end
      READ, WRITE: begin
        if (resp_i) begin
          beat_ack = 1'b1;
          if (last_beat) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      line_q  <= '0;
      line_o  <= '0;
      addr_q  <= '0;
      op_wr   <= 1'b0;
      read_o  <= 1'b0;
      write_o <= 1'b0;
      resp_o  <= 1'b0;
    end else begin
      state   <= state_next;
      // Memory requests are flops that track the next state, so they are
      // glitch-free and high exactly while the FSM sits in READ / WRITE.
      read_o  <= (state_next == READ);
      write_o <= (state_next == WRITE);
      resp_o  <= (state == DONE);
      if (start_wr) begin
        line_q <= line_i;
        addr_q <= address_i;
        cnt    <= '0;
        op_wr  <= 1'b1;
      end
      if (start_rd) begin
        addr_q <= address_i;
        cnt    <= '0;
        op_wr  <= 1'b0;
      end
      if (beat_ack) begin
        if (state == READ) line_o[s_burst*cnt +: s_burst] <= burst_i;
        cnt <= last_beat ? '0 : cnt + cw'(1);
      end
    end
  end

  assign address_o = {addr_q[31:offw], {offw{1'b0}}};
  // Always drives the current beat of the latched line; zero after reset.
  assign burst_o   = line_q[s_burst*cnt +: s_burst];

`ifdef CACHELINE_ADAPTOR_PERF_EN
  // Counted as DONE is left, i.e. on the same edge that raises resp_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == DONE) begin
      if (op_wr) wr_count <= wr_count + 32'd1;
      else       rd_count <= rd_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter s_line, default 256, cacheline width in bits.
REQ-002 SHALL have parameter s_burst, default 64, memory beat width in bits; beats = s_line/s_burst (4 by default).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port line_i  input  s_line  cache writeback line (pmem_wdata of the cache).
REQ-006 SHALL have port line_o  output  s_line  assembled fill line (pmem_rdata of the cache).
REQ-007 SHALL have port address_i  input  32  cache line address.
REQ-008 SHALL have port read_i  input  1  cache line-read request, level, held until resp_o.
REQ-009 SHALL have port write_i  input  1  cache line-write request, level, held until resp_o.
REQ-010 SHALL have port resp_o  output  1  one-cycle completion pulse to cache.
REQ-011 SHALL have port burst_i  input  s_burst  memory read beat.
REQ-012 SHALL have port burst_o  output  s_burst  memory write beat.
REQ-013 SHALL have port address_o  output  32  memory address, line-aligned.
REQ-014 SHALL have ports read_o, write_o  output  1  memory requests, registered.
REQ-015 SHALL have port resp_i  input  1  memory beat acknowledge, one per beat.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE, DONE plus a beat counter of width clog2(beats).
REQ-017 In IDLE with write_i=1, SHALL latch line_i and address_i, clear counter, enter WRITE; write_i has priority over read_i if both high.
REQ-018 In IDLE with read_i=1 and write_i=0, SHALL latch address_i, clear counter, enter READ.
REQ-019 address_o SHALL equal latched address with bits [clog2(s_line/8)-1:0] forced to zero.
REQ-020 read_o SHALL be 1 exactly while in READ; write_o exactly while in WRITE.
REQ-021 In READ, on each cycle with resp_i=1, SHALL store burst_i into line_o bits [s_burst*k +: s_burst], k = counter, then increment counter.
REQ-022 In WRITE, burst_o SHALL present latched line bits [s_burst*k +: s_burst]; on resp_i=1 counter increments.
REQ-023 On the resp_i beat with k = beats-1, SHALL enter DONE; counter wraps to 0.
REQ-024 In DONE, resp_o SHALL be 1 for exactly one cycle, then FSM returns to IDLE.
REQ-025 Minimum latency: request sampled at edge 0, read_o/write_o high after edge 0, memory beats at earliest edges 1..4, resp_o high after edge 5.
REQ-026 read_i/write_i changes outside IDLE SHALL be ignored; resp_i in IDLE or DONE SHALL be ignored.
REQ-027 line_o SHALL hold its value until overwritten by a subsequent read beat; writes never modify line_o.
REQ-028 burst_o SHALL be don't-care outside WRITE but SHALL not be X after reset (drives beat 0 of latched line).

Reset
REQ-029 rst=1 SHALL immediately force IDLE, counter 0, read_o=0, write_o=0, resp_o=0, address_o=0, line_o=0, latched line 0.
REQ-030 Reset mid-burst SHALL abort the transfer with no resp_o; partial line_o content is cleared.

Configuration
REQ-031 Macro CACHELINE_ADAPTOR_PERF_EN defined: SHALL add outputs rd_count and wr_count (32 bits each, reset 0), incremented on each resp_o of a read/write, wrapping at 2^32-1 to 0.
REQ-032 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-033 Read: address_i=0x0000_1234, read_i=1, memory beats 0x11..11,0x22..22,0x33..33,0x44..44 -> address_o=0x0000_1220, line_o={0x44..44,0x33..33,0x22..22,0x11..11}, one resp_o pulse.
REQ-034 Write: line_i={0xDD..DD,0xCC..CC,0xBB..BB,0xAA..AA}, address_i=0x8000_00E0 -> burst_o sequence 0xAA..AA,0xBB..BB,0xCC..CC,0xDD..DD, write_o low after 4th resp_i, one resp_o.
REQ-035 read_i=write_i=1 in IDLE -> WRITE taken, read_o stays 0, one resp_o.
REQ-036 Read with resp_i gaps (beats at edges 2,5,6,9) -> correct line_o, resp_o one cycle after edge 9's transition to DONE.
REQ-037 rst asserted after 2nd read beat -> read_o=0 same cycle, no resp_o, line_o=0; next read completes normally.
REQ-038 With CACHELINE_ADAPTOR_PERF_EN: 3 reads, 2 writes -> rd_count=3, wr_count=2.
